// File: rtl/ws2812_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_driver
// Brief    : WS2812 chain driver with host-written GRB buffer, triggered frames
//            and per-frame global brightness scaling.
// Revision : 1.0  initial release
// ============================================================================
module ws2812_frame_driver #(
    parameter int CLK_FRE  = 50_000_000,
    parameter int LED_NUM  = 64,
    parameter int T0H_NS   = 400,
    parameter int T0L_NS   = 850,
    parameter int T1H_NS   = 800,
    parameter int T1L_NS   = 450,
    parameter int RESET_US = 300,
    parameter int ADDR_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ws2812_di
);
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * 16'({1'b0, b} + 9'd1);
        return prod[15:8];
    endfunction

    localparam int c_MHZ   = CLK_FRE / 1_000_000;
    localparam int c_T0H   = at_least_one(c_MHZ * T0H_NS / 1000);
    localparam int c_T0L   = at_least_one(c_MHZ * T0L_NS / 1000);
    localparam int c_T1H   = at_least_one(c_MHZ * T1H_NS / 1000);
    localparam int c_T1L   = at_least_one(c_MHZ * T1L_NS / 1000);
    localparam int c_RST   = at_least_one(c_MHZ * RESET_US);
    localparam int c_MAX   = max2(max2(max2(c_T0H, c_T0L), max2(c_T1H, c_T1L)), c_RST);
    // One shared duration counter, sized for the longest interval it must reach.
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_T0H_L = c_CNT_W'(c_T0H - 1);
    localparam logic [c_CNT_W-1:0] c_T0L_L = c_CNT_W'(c_T0L - 1);
    localparam logic [c_CNT_W-1:0] c_T1H_L = c_CNT_W'(c_T1H - 1);
    localparam logic [c_CNT_W-1:0] c_T1L_L = c_CNT_W'(c_T1L - 1);
    localparam logic [c_CNT_W-1:0] c_RST_L = c_CNT_W'(c_RST - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_IDX = ADDR_W'(LED_NUM - 1);
    localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W + 1)'(LED_NUM);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_HIGH  = 3'd2;
    localparam logic [2:0] c_LOW   = 3'd3;
    localparam logic [2:0] c_LATCH = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_idx;
    logic [4:0]         r_bit;
    logic [23:0]        r_word;
    logic [7:0]         r_bright;
    logic [23:0]        mem [LED_NUM];
    logic [23:0]        w_pix;
    logic [23:0]        w_load_word;
    logic [c_CNT_W-1:0] w_hi_last;
    logic [c_CNT_W-1:0] w_lo_last;

    // No reset on the buffer so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < c_DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign w_pix       = mem[r_idx];
    assign w_load_word = {scale8(w_pix[23:16], r_bright),
                          scale8(w_pix[15:8],  r_bright),
                          scale8(w_pix[7:0],   r_bright)};
    assign w_hi_last   = r_word[23] ? c_T1H_L : c_T0H_L;
    assign w_lo_last   = r_word[23] ? c_T1L_L : c_T0L_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_LOAD;
            c_LOAD:  w_next = c_HIGH;
            c_HIGH:  if (r_cnt == w_hi_last) w_next = c_LOW;
            c_LOW: begin
                if (r_cnt == w_lo_last) begin
                    if (r_bit != 5'd23)           w_next = c_HIGH;
                    else if (r_idx != c_LAST_IDX) w_next = c_LOAD;
                    else                          w_next = c_LATCH;
                end
            end
            c_LATCH: if (r_cnt == c_RST_L) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_IDLE);
        ws2812_di = (r_state == c_HIGH);
        done      = (r_state == c_LATCH) && (r_cnt == c_RST_L);
    end

    // Counter restarts on every state change so each interval is timed from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_bright <= '0;
        end else begin
            r_cnt <= ((w_next != r_state) || (r_state == c_IDLE)) ? '0 : r_cnt + 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_bright <= brightness;
                        r_idx    <= '0;
                    end
                end
                c_LOAD: begin
                    r_word <= w_load_word;
                    r_bit  <= '0;
                end
                c_LOW: begin
                    if (r_cnt == w_lo_last) begin
                        r_word <= {r_word[22:0], 1'b0};
                        r_bit  <= r_bit + 5'd1;
                        if (w_next == c_LOAD) r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_driver
// Brief    : Self-checking bench; frames are compared against a waveform model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ws2812_frame_driver;
    localparam int CLK  = 50_000_000;
    localparam int LEDS = 3;
    localparam int AW   = 2;
    localparam int RUS  = 20;
    localparam int MHZ  = CLK / 1_000_000;
    localparam int TH0  = MHZ * 400 / 1000;
    localparam int TL0  = MHZ * 850 / 1000;
    localparam int TH1  = MHZ * 800 / 1000;
    localparam int TL1  = MHZ * 450 / 1000;
    localparam int RSTC = MHZ * RUS;
    localparam int BUDGET = LEDS * (1 + 24 * 70) + RSTC + 200;

    logic          clk = 1'b0;
    logic          rst, wr_en, start;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [7:0]    brightness;
    logic          busy, done, ws2812_di;

    ws2812_frame_driver #(
        .CLK_FRE(CLK), .LED_NUM(LEDS), .T0H_NS(400), .T0L_NS(850),
        .T1H_NS(800), .T1L_NS(450), .RESET_US(RUS), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .brightness(brightness), .start(start), .busy(busy), .done(done),
        .ws2812_di(ws2812_di)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] model   [LEDS];
    logic [23:0] last_px [LEDS];
    int          act_n[$];
    int          act_a[$];
    logic [23:0] act_d[$];
    int          restart_at = -1;
    int          rst_at     = -1;
    int          g_blen, g_first_hi, g_first_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] px, input int br);
        int g, r, b;
        g = int'(px[23:16]) * (br + 1) / 256;
        r = int'(px[15:8])  * (br + 1) / 256;
        b = int'(px[7:0])   * (br + 1) / 256;
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    task automatic wr(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < LEDS) model[a] = d;
    endtask

    // Runs one frame from IDLE; expected line waveform is built from the pixel rules.
    task automatic frame(input int br);
        bit          wave[$];
        bit          expw[$];
        bit          bits[$];
        int          load_at [LEDS];
        logic [23:0] expx [LEDS];
        logic [23:0] v, dec;
        int          n, dcnt, dpos, mism, run, lim;
        bit          aborted;

        for (int p = 0; p < LEDS; p++) begin
            load_at[p] = expw.size();
            v = model[p];
            for (int k = 0; k < act_n.size(); k++)
                if (act_a[k] == p && act_n[k] < load_at[p]) v = act_d[k];
            expx[p] = scale(v, br);
            expw.push_back(1'b0);
            for (int b = 23; b >= 0; b--) begin
                repeat (expx[p][b] ? TH1 : TH0) expw.push_back(1'b1);
                repeat (expx[p][b] ? TL1 : TL0) expw.push_back(1'b0);
            end
        end
        repeat (RSTC) expw.push_back(1'b0);

        start = 1'b1; brightness = 8'(br);
        @(negedge clk);
        start = 1'b0; brightness = 8'($urandom);
        n = 0; dcnt = 0; dpos = -1; aborted = 1'b0;
        while (n < BUDGET) begin
            if (rst) begin
                check("abort_di", ws2812_di, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                rst = 1'b0; aborted = 1'b1;
                break;
            end
            if (!busy) break;
            wave.push_back(ws2812_di);
            if (done) begin dcnt++; dpos = n; end
            if (n == rst_at) begin
                check("rst_in_high", ws2812_di, 1);
                rst = 1'b1;
            end
            start = (n == restart_at);
            wr_en = 1'b0;
            for (int k = 0; k < act_n.size(); k++)
                if (act_n[k] == n) begin
                    wr_en = 1'b1; wr_addr = AW'(act_a[k]); wr_data = act_d[k];
                end
            n++;
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        g_blen = wave.size();

        if (aborted) begin
            check("abort_nodone", dcnt, 0);
        end else begin
            check("frame_end", busy, 0);
            check("busy_len", wave.size(), expw.size());
            check("done_cnt", dcnt, 1);
            check("done_pos", dpos, wave.size() - 1);
            mism = 0;
            lim = (wave.size() < expw.size()) ? wave.size() : expw.size();
            for (int i = 0; i < lim; i++) if (wave[i] !== expw[i]) mism++;
            check("wave", mism, 0);
            run = 0; g_first_hi = -1; g_first_lo = 0;
            for (int i = 0; i < wave.size(); i++) begin
                if (wave[i]) begin
                    run++;
                end else if (run > 0) begin
                    bits.push_back(run > (TH0 + TH1) / 2);
                    if (g_first_hi < 0) g_first_hi = run;
                    run = 0;
                end
                if (!wave[i] && bits.size() == 1 && run == 0 && g_first_hi >= 0) g_first_lo++;
            end
            check("nbits", bits.size(), 24 * LEDS);
            for (int p = 0; p < LEDS; p++) begin
                dec = '0;
                for (int b = 0; b < 24; b++)
                    if (24 * p + b < bits.size()) dec = {dec[22:0], bits[24 * p + b]};
                last_px[p] = dec;
                check($sformatf("px%0d", p), dec, expx[p]);
            end
        end
        for (int k = 0; k < act_n.size(); k++)
            if (act_a[k] < LEDS) model[act_a[k]] = act_d[k];
        act_n.delete(); act_a.delete(); act_d.delete();
        restart_at = -1;
    endtask

    initial begin
        logic [23:0] old0, new1, new0;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; brightness = '0;
        repeat (3) @(negedge clk);
        check("rst_di", ws2812_di, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic timing: MSB and LSB set, identity brightness.
        wr(0, 24'h800001); wr(1, 24'($urandom)); wr(2, 24'($urandom));
        frame(255);
        check("first_hi", g_first_hi, TH1);
        check("first_lo", g_first_lo, TL1);
        check("frame_len", g_blen, LEDS * (1 + 24 * (TH0 + TL0)) + RSTC);
        check("px0_const", last_px[0], 24'h800001);
        repeat (5) @(negedge clk);

        // Brightness scaling.
        wr(0, 24'hFF00FF);
        frame(127);
        check("br127", last_px[0], 24'h7F007F);
        @(negedge clk);
        frame(0);
        check("br0", last_px[0], 24'h000000);
        @(negedge clk);

        // Start while busy is ignored; start right after done starts a new frame.
        restart_at = 100;
        frame(int'($urandom_range(0, 255)));
        frame(int'($urandom_range(0, 255)));
        @(negedge clk);

        // Mid-frame writes: pixel 1 before its LOAD, pixel 0 after its LOAD.
        old0 = model[0]; new1 = 24'($urandom); new0 = 24'($urandom);
        act_n.push_back(200); act_a.push_back(1); act_d.push_back(new1);
        act_n.push_back(300); act_a.push_back(0); act_d.push_back(new0);
        frame(255);
        check("midwr_px1_new", last_px[1], new1);
        check("midwr_px0_old", last_px[0], old0);
        frame(255);
        check("midwr_px0_next", last_px[0], new0);
        @(negedge clk);

        // Out-of-range address leaves the buffer untouched.
        wr(LEDS, 24'hFFFFFF);
        frame(255);
        check("oob_px0", last_px[0], new0);
        check("oob_px2", last_px[2], model[2]);
        @(negedge clk);

        // Reset during the high phase of bit 5, then a clean full frame.
        rst_at = 1 + 4 * (TH0 + TL0) + 3;
        frame(255);
        rst_at = -1;
        repeat (3) @(negedge clk);
        frame(255);
        @(negedge clk);

        // Random pixels, brightness and in-frame writes.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) wr(int'($urandom_range(0, LEDS)), 24'($urandom));
            act_n.push_back(int'($urandom_range(0, 4000)));
            act_a.push_back(int'($urandom_range(0, LEDS - 1)));
            act_d.push_back(24'($urandom));
            frame(int'($urandom_range(0, 255)));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
